sync_fifo_ctrl: RTL
===================

Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO for same-domain buffering between pipeline stages. It is the single-clock successor to the team's dual-clock FIFO and adds several features: a selectable read mode, runtime-programmable early-warning thresholds, synchronous flush, and sticky overflow/underflow error flags. Occupancy is tracked by a registered count, so there is no pointer-synchronisation latency.

Parameters:
FIFO_WIDTH, 8, data word width in bits (>=1)
FIFO_DEPTH, 16, number of entries; must be a power of two, >=2
FIFO_AWIDTH, $clog2(FIFO_DEPTH), address width; derived, do not override
READ_FALL_THROUGH, "TRUE", "TRUE" = head word visible combinationally; "FALSE" = registered read with 1-cycle latency

Ports:
fifo_clk  in  1  sole clock, all logic on rising edge
fifo_rst_n  in  1  asynchronous, active-low reset
fifo_flush  in  1  synchronous clear of contents and error flags
fifo_wen  in  1  write request
fifo_wdata  in  FIFO_WIDTH  write data
fifo_ren  in  1  read request
fifo_rdata  out  FIFO_WIDTH  read data
fifo_rvalid  out  1  fifo_rdata valid this cycle
fifo_afull_thresh  in  FIFO_AWIDTH+1  almost-full threshold
fifo_aempty_thresh  in  FIFO_AWIDTH+1  almost-empty threshold
fifo_full  out  1  count == FIFO_DEPTH
fifo_empty  out  1  count == 0
fifo_almost_full  out  1  count >= fifo_afull_thresh
fifo_almost_empty  out  1  count <= fifo_aempty_thresh
fifo_count  out  FIFO_AWIDTH+1  current occupancy, 0..FIFO_DEPTH
fifo_overflow  out  1  sticky: write attempted while full
fifo_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (fifo_rst_n low, async): wptr, rptr and count go to 0. fifo_empty=1, fifo_full=0, fifo_almost_empty=1 when aempty_thresh>=0, fifo_overflow=0, fifo_underflow=0, fifo_rvalid=0, registered fifo_rdata=0. Memory is not reset.
- Accepted write: fifo_write = fifo_wen & ~fifo_full. Accepted read: fifo_read = fifo_ren & ~fifo_empty. Both are evaluated on pre-edge flags.
- Pointers are FIFO_AWIDTH+1 bits. The memory address is the low FIFO_AWIDTH bits; wrap-around is natural binary rollover.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- All status flags are derived from the registered count only, never from the inputs.
- Full + simultaneous wen/ren: the read is accepted and the write is rejected. Count goes to DEPTH-1 and fifo_overflow is set.
- Empty + simultaneous wen/ren: the write is accepted and the read is rejected. Count goes to 1 and fifo_underflow is set.
- Write-to-visibility latency: fifo_empty deasserts on the edge after the accepted write (1 cycle).
- READ_FALL_THROUGH="TRUE":
  - fifo_rdata = mem[raddr] combinationally.
  - fifo_rvalid = ~fifo_empty.
  - fifo_read pops the head at the clock edge.
- READ_FALL_THROUGH="FALSE":
  - On fifo_read, fifo_rdata <= mem[raddr] at the edge and fifo_rvalid is 1 for exactly the following cycle.
  - fifo_rdata holds its last value otherwise.
  - fifo_rvalid=0 after a rejected read.
- fifo_flush: synchronous and has priority over wen/ren in the same cycle. Pointers and count go to 0, both sticky flags clear, fifo_rvalid goes to 0. No write is stored in the flush cycle.
- Sticky flags: set on a rejected request, held until fifo_flush or reset.
- Thresholds:
  - Sampled live each cycle and compared unsigned.
  - fifo_afull_thresh=0 makes fifo_almost_full constantly 1.
  - Values above FIFO_DEPTH make fifo_almost_full constantly 0.
  - fifo_aempty_thresh>=FIFO_DEPTH makes fifo_almost_empty constantly 1.
- Reset asserted mid-burst: all state clears immediately. Operations in flight are lost; no partial writes are committed after reset release.

Test Plan:
- Reset then fill: DEPTH=16, 16 writes of 0x00..0x0F -> fifo_count=16, fifo_full=1 after the 16th edge. A 17th write sets fifo_overflow=1, and the count stays 16.
- Drain in FWFT mode: from full, assert ren for 16 cycles -> rdata sequence 0x00..0x0F, fifo_empty=1 after the last edge. A further ren sets fifo_underflow=1.
- Registered mode: READ_FALL_THROUGH="FALSE", write 0xA5, then ren -> fifo_rvalid=1 with rdata=0xA5 exactly one cycle after ren, rvalid=0 the next cycle.
- Simultaneous at boundaries: at full, wen+ren -> count=15 and overflow=1. At empty, wen+ren with 0x3C -> count=1, underflow=1, head=0x3C.
- Wrap and thresholds: afull_thresh=12, aempty_thresh=3, with 40 cycles of interleaved wr/rd crossing the pointer wrap -> data order preserved. almost_full toggles exactly at count 12, almost_empty at count 3.
- Flush and reset: flush with wen=1 at count=9 -> count=0, sticky flags cleared, flush-cycle word not stored. Drop fifo_rst_n asynchronously mid-write burst -> outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO for buffering between pipeline stages in one clock domain.
// Occupancy is kept in a registered count. Every status flag is decoded from
// that count alone, so the flags never depend combinationally on the request
// inputs.
//
// Parameters
//   FIFO_WIDTH         data word width in bits (>= 1)
//   FIFO_DEPTH         number of entries, power of two, >= 2
//   FIFO_AWIDTH        memory address width, derived from FIFO_DEPTH
//   READ_FALL_THROUGH  "TRUE"  : head word driven combinationally (FWFT)
//                      "FALSE" : registered read, data one cycle after ren
//
// Ports
//   fifo_clk            sole clock, rising edge
//   fifo_rst_n          asynchronous active-low reset
//   fifo_flush          synchronous clear of contents and error flags
//   fifo_wen/fifo_wdata write request and data
//   fifo_ren            read request
//   fifo_rdata          read data
//   fifo_rvalid         fifo_rdata valid this cycle
//   fifo_afull_thresh   almost-full threshold  (count >= thresh)
//   fifo_aempty_thresh  almost-empty threshold (count <= thresh)
//   fifo_full/empty     count == FIFO_DEPTH / count == 0
//   fifo_almost_full/almost_empty  threshold compares against count
//   fifo_count          occupancy, 0..FIFO_DEPTH
//   fifo_overflow       sticky, write attempted while full
//   fifo_underflow      sticky, read attempted while empty
//
// Handshake: a write is accepted when fifo_wen is high and fifo_full is low
// before the edge; a read is accepted when fifo_ren is high and fifo_empty is
// low before the edge. A rejected request is dropped and sets its sticky flag.
// Flush takes priority over both requests in the same cycle.
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int    FIFO_WIDTH        = 8,
  parameter int    FIFO_DEPTH        = 16,
  parameter int    FIFO_AWIDTH       = $clog2(FIFO_DEPTH),
  parameter string READ_FALL_THROUGH = "TRUE"
) (
  input  logic                   fifo_clk,
  input  logic                   fifo_rst_n,
  input  logic                   fifo_flush,
  input  logic                   fifo_wen,
  input  logic [FIFO_WIDTH-1:0]  fifo_wdata,
  input  logic                   fifo_ren,
  output logic [FIFO_WIDTH-1:0]  fifo_rdata,
  output logic                   fifo_rvalid,
  input  logic [FIFO_AWIDTH:0]   fifo_afull_thresh,
  input  logic [FIFO_AWIDTH:0]   fifo_aempty_thresh,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   fifo_almost_full,
  output logic                   fifo_almost_empty,
  output logic [FIFO_AWIDTH:0]   fifo_count,
  output logic                   fifo_overflow,
  output logic                   fifo_underflow
);

  localparam logic [FIFO_AWIDTH:0] DEPTH_C = (FIFO_AWIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AWIDTH:0] ONE_C   = (FIFO_AWIDTH+1)'(1);

  logic [FIFO_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_AWIDTH:0]   wptr;
  logic [FIFO_AWIDTH:0]   rptr;
  logic [FIFO_AWIDTH:0]   count;
  logic                   overflow_q;
  logic                   underflow_q;
  logic                   fifo_write;
  logic                   fifo_read;
  logic [FIFO_AWIDTH-1:0] waddr;
  logic [FIFO_AWIDTH-1:0] raddr;

  // Pointers carry one extra bit; the memory only sees the low bits, so the
  // wrap is plain binary rollover.
  assign waddr = wptr[FIFO_AWIDTH-1:0];
  assign raddr = rptr[FIFO_AWIDTH-1:0];

  // Status flags come from the registered count only.
  assign fifo_full         = (count == DEPTH_C);
  assign fifo_empty        = (count == '0);
  assign fifo_almost_full  = (count >= fifo_afull_thresh);
  assign fifo_almost_empty = (count <= fifo_aempty_thresh);
  assign fifo_count        = count;
  assign fifo_overflow     = overflow_q;
  assign fifo_underflow    = underflow_q;

  // Acceptance uses the pre-edge flags. At full a simultaneous read still
  // goes through while the write is refused; at empty the reverse holds.
  assign fifo_write = fifo_wen & ~fifo_full;
  assign fifo_read  = fifo_ren & ~fifo_empty;

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (fifo_flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fifo_write) wptr <= wptr + ONE_C;
      if (fifo_read)  rptr <= rptr + ONE_C;
      if (fifo_write && !fifo_read) begin
        count <= count + ONE_C;
      end else if (fifo_read && !fifo_write) begin
        count <= count - ONE_C;
      end
      if (fifo_wen && fifo_full)  overflow_q  <= 1'b1;
      if (fifo_ren && fifo_empty) underflow_q <= 1'b1;
    end
  end

  // Storage is not reset. Writes are suppressed during flush and while reset
  // is held so nothing from an interrupted burst lands in the array.
  always_ff @(posedge fifo_clk) begin
    if (fifo_write && !fifo_flush && fifo_rst_n) begin
      mem[waddr] <= fifo_wdata;
    end
  end

  if (READ_FALL_THROUGH == "TRUE") begin : g_fwft
    // Head word is always presented; a read simply advances rptr.
    assign fifo_rdata  = mem[raddr];
    assign fifo_rvalid = ~fifo_empty;
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // rvalid is a one-cycle pulse per accepted read; rdata holds between
    // reads so downstream can sample it late.
    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (fifo_flush) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= fifo_read;
        if (fifo_read) rdata_q <= mem[raddr];
      end
    end

    assign fifo_rdata  = rdata_q;
    assign fifo_rvalid = rvalid_q;
  end

endmodule
